// File: rtl/ram_slot_arbiter.sv
// SRAM slot arbiter: the 6502 bus owns S4-S7 of each bus cycle, and one background
// fill/copy/checksum access runs in the PHI1 slot S1-S3 while the phase stays locked.
module ram_slot_arbiter #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 8
) (
  input  logic              C7M,
  input  logic              nRES,
  input  logic [2:0]        S,
  input  logic              bus_sel,
  input  logic              bus_we,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic [DATA_W-1:0] bus_wdata,
  input  logic              bg_req,
  input  logic              bg_we,
  input  logic [ADDR_W-1:0] bg_addr,
  input  logic [DATA_W-1:0] bg_wdata,
  output logic              bg_gnt,
  output logic              bg_done,
  output logic              bg_abort,
  output logic [DATA_W-1:0] bg_rdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_oe,
  output logic              ram_cs,
  output logic              ram_we_n
);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    DONE
  } bgState_e;

  bgState_e state;
  bgState_e stateNext;

  logic              bgWe;
  logic              bgWeNext;
  logic              gntNext;
  logic              doneNext;
  logic              abortNext;
  logic [DATA_W-1:0] rdataNext;
  logic [ADDR_W-1:0] addrNext;
  logic [DATA_W-1:0] wdataNext;
  logic              oeNext;
  logic              csNext;
  logic              weNNext;
  logic              busPathOn;
  logic              busOwn;

  // The bus decode is sampled one slot early (S3..S6) so the pins are driven during S4..S7.
  assign busOwn = bus_sel && (S >= 3'd3) && (S <= 3'd6);

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      bgWe      <= 1'b0;
      bg_gnt    <= 1'b0;
      bg_done   <= 1'b0;
      bg_abort  <= 1'b0;
      bg_rdata  <= '0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      ram_oe    <= 1'b0;
      ram_cs    <= 1'b0;
      ram_we_n  <= 1'b1;
    end else begin
      bgWe      <= bgWeNext;
      bg_gnt    <= gntNext;
      bg_done   <= doneNext;
      bg_abort  <= abortNext;
      bg_rdata  <= rdataNext;
      ram_addr  <= addrNext;
      ram_wdata <= wdataNext;
      ram_oe    <= oeNext;
      ram_cs    <= csNext;
      ram_we_n  <= weNNext;
    end
  end

  always_comb begin
    stateNext = state;
    bgWeNext  = bgWe;
    gntNext   = bg_gnt;
    doneNext  = 1'b0;
    abortNext = 1'b0;
    rdataNext = bg_rdata;
    addrNext  = ram_addr;
    wdataNext = ram_wdata;
    oeNext    = ram_oe;
    csNext    = ram_cs;
    weNNext   = ram_we_n;
    busPathOn = 1'b0;

    case (state)
      IDLE: begin
        if (S == 3'd1 && bg_req && !bus_sel) begin
          // ram_addr/ram_wdata double as the latched background address and data.
          stateNext = SETUP;
          bgWeNext  = bg_we;
          gntNext   = 1'b1;
          csNext    = 1'b1;
          oeNext    = bg_we;
          weNNext   = 1'b1;
          addrNext  = bg_addr;
          wdataNext = bg_wdata;
        end else begin
          busPathOn = 1'b1;
        end
      end

      SETUP: begin
        if (S == 3'd2 && !bus_sel) begin
          stateNext = STROBE;
          weNNext   = ~bgWe;
        end else begin
          stateNext = IDLE;
          abortNext = 1'b1;
          gntNext   = 1'b0;
          csNext    = 1'b0;
          oeNext    = 1'b0;
          weNNext   = 1'b1;
          busPathOn = 1'b1;
        end
      end

      STROBE: begin
        if (S == 3'd3 && !bus_sel) begin
          stateNext = DONE;
          weNNext   = 1'b1;
          doneNext  = 1'b1;
          gntNext   = 1'b0;
          csNext    = 1'b0;
          oeNext    = 1'b0;
          if (!bgWe) begin
            rdataNext = ram_rdata;
          end
        end else begin
          // A write aborted here may already have landed; the requester retries regardless.
          stateNext = IDLE;
          abortNext = 1'b1;
          gntNext   = 1'b0;
          csNext    = 1'b0;
          oeNext    = 1'b0;
          weNNext   = 1'b1;
          busPathOn = 1'b1;
        end
      end

      DONE: begin
        stateNext = IDLE;
        busPathOn = 1'b1;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase

    if (busPathOn) begin
      if (busOwn) begin
        csNext    = 1'b1;
        addrNext  = bus_addr;
        wdataNext = bus_wdata;
        oeNext    = bus_we;
        weNNext   = ~(bus_we && (S == 3'd4 || S == 3'd5));
      end else begin
        csNext  = 1'b0;
        oeNext  = 1'b0;
        weNNext = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ram_slot_arbiter.sv
// Bench for ram_slot_arbiter: directed slot scenarios followed by randomized phase/bus/background
// traffic, all checked every cycle against a transaction-level model of SRAM ownership.
module tb_ram_slot_arbiter;

  logic        C7M;
  logic        nRES;
  logic [2:0]  S;
  logic        bus_sel;
  logic        bus_we;
  logic [19:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bg_req;
  logic        bg_we;
  logic [19:0] bg_addr;
  logic [7:0]  bg_wdata;
  logic        bg_gnt;
  logic        bg_done;
  logic        bg_abort;
  logic [7:0]  bg_rdata;
  logic [7:0]  ram_rdata;
  logic [19:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_oe;
  logic        ram_cs;
  logic        ram_we_n;

  int vectors;
  int miscompares;
  int obsDone;
  int obsAbort;
  int obsWeLow;

  // Reference model: an in-flight background transaction plus the expected pin image.
  logic        bgActive;
  int          bgSlots;
  logic        recWe;
  logic        coolDown;
  logic        eGnt;
  logic        eDone;
  logic        eAbort;
  logic [7:0]  eRdata;
  logic [19:0] eAddr;
  logic [7:0]  eWdata;
  logic        eOe;
  logic        eCs;
  logic        eWeN;

  ram_slot_arbiter #(.ADDR_W(20), .DATA_W(8)) dut (
    .C7M(C7M), .nRES(nRES), .S(S),
    .bus_sel(bus_sel), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bg_req(bg_req), .bg_we(bg_we), .bg_addr(bg_addr), .bg_wdata(bg_wdata),
    .bg_gnt(bg_gnt), .bg_done(bg_done), .bg_abort(bg_abort), .bg_rdata(bg_rdata),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_oe(ram_oe), .ram_cs(ram_cs), .ram_we_n(ram_we_n)
  );

  initial begin
    C7M = 1'b0;
    forever #5 C7M = ~C7M;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    bgActive = 1'b0;
    bgSlots  = 0;
    recWe    = 1'b0;
    coolDown = 1'b0;
    eGnt = 1'b0; eDone = 1'b0; eAbort = 1'b0; eRdata = '0;
    eAddr = '0; eWdata = '0; eOe = 1'b0; eCs = 1'b0; eWeN = 1'b1;
  endtask

  // The bus takes the pins whenever it is selected for the S4-S7 window; otherwise they go idle.
  task automatic modelBus();
    if (bus_sel && S >= 3 && S <= 6) begin
      eCs    = 1'b1;
      eAddr  = bus_addr;
      eWdata = bus_wdata;
      eOe    = bus_we;
      eWeN   = !(bus_we && (S == 4 || S == 5));
    end else begin
      eCs  = 1'b0;
      eOe  = 1'b0;
      eWeN = 1'b1;
    end
  endtask

  task automatic modelStep();
    logic wasCool;
    eDone  = 1'b0;
    eAbort = 1'b0;
    if (!nRES) begin
      modelReset();
    end else if (bgActive) begin
      if (S == 3'(2 + bgSlots) && !bus_sel) begin
        if (bgSlots == 0) begin
          eWeN    = !recWe;
          bgSlots = 1;
        end else begin
          if (!recWe) eRdata = ram_rdata;
          eWeN = 1'b1; eDone = 1'b1; eGnt = 1'b0; eCs = 1'b0; eOe = 1'b0;
          bgActive = 1'b0;
          coolDown = 1'b1;
        end
      end else begin
        bgActive = 1'b0;
        eAbort = 1'b1; eGnt = 1'b0; eCs = 1'b0; eOe = 1'b0; eWeN = 1'b1;
        modelBus();
      end
    end else begin
      wasCool  = coolDown;
      coolDown = 1'b0;
      if (!wasCool && S == 1 && bg_req && !bus_sel) begin
        bgActive = 1'b1;
        bgSlots  = 0;
        recWe    = bg_we;
        eGnt = 1'b1; eCs = 1'b1; eOe = bg_we; eWeN = 1'b1;
        eAddr = bg_addr; eWdata = bg_wdata;
      end else begin
        modelBus();
      end
    end
  endtask

  task automatic checkAll();
    checkOutput("bg_gnt", bg_gnt, eGnt);
    checkOutput("bg_done", bg_done, eDone);
    checkOutput("bg_abort", bg_abort, eAbort);
    checkOutput("bg_rdata", bg_rdata, eRdata);
    checkOutput("ram_addr", ram_addr, eAddr);
    checkOutput("ram_wdata", ram_wdata, eWdata);
    checkOutput("ram_oe", ram_oe, eOe);
    checkOutput("ram_cs", ram_cs, eCs);
    checkOutput("ram_we_n", ram_we_n, eWeN);
    if (ram_we_n === 1'b0) checkOutput("inv_we_cs_oe", {ram_cs, ram_oe}, 2'b11);
    if (bg_done === 1'b1) obsDone++;
    if (bg_abort === 1'b1) obsAbort++;
    if (ram_we_n === 1'b0) obsWeLow++;
  endtask

  task automatic applyStimulus(input logic [2:0] s);
    S = s;
    @(posedge C7M);
    modelStep();
    #1;
    checkAll();
  endtask

  task automatic clearCounts();
    obsDone  = 0;
    obsAbort = 0;
    obsWeLow = 0;
  endtask

  initial begin
    logic [2:0] sNow;
    logic       busCyc;
    vectors = 0; miscompares = 0;
    clearCounts();
    modelReset();
    nRES = 1'b0; S = 3'd0;
    bus_sel = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
    bg_req = 1'b0; bg_we = 1'b0; bg_addr = '0; bg_wdata = '0; ram_rdata = '0;

    // Reset held, then released with nothing requested.
    for (int i = 0; i < 14; i++) applyStimulus(3'(1 + i % 7));
    nRES = 1'b1;
    for (int i = 1; i <= 7; i++) applyStimulus(3'(i));

    // Background read of 0x12345; request drops after grant and the inputs go stale.
    clearCounts();
    bg_req = 1'b1; bg_we = 1'b0; bg_addr = 20'h12345; ram_rdata = 8'hA5;
    applyStimulus(3'd1);
    checkOutput("t2_cs_at_grant", ram_cs, 1'b1);
    bg_req = 1'b0; bg_addr = 20'h0BEEF;
    applyStimulus(3'd2);
    applyStimulus(3'd3);
    ram_rdata = 8'h5A;
    for (int i = 4; i <= 7; i++) applyStimulus(3'(i));
    checkOutput("t2_done_pulses", obsDone, 1);
    checkOutput("t2_we_low", obsWeLow, 0);
    checkOutput("t2_rdata", bg_rdata, 8'hA5);

    // Background write of 0x3C to 0x00FFF: one slot of write strobe.
    clearCounts();
    bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h00FFF; bg_wdata = 8'h3C;
    applyStimulus(3'd1);
    bg_req = 1'b0; bg_wdata = 8'hC3;
    applyStimulus(3'd2);
    checkOutput("t3_wdata", ram_wdata, 8'h3C);
    checkOutput("t3_strobe", ram_we_n, 1'b0);
    for (int i = 3; i <= 7; i++) applyStimulus(3'(i));
    checkOutput("t3_we_low", obsWeLow, 1);
    checkOutput("t3_done_pulses", obsDone, 1);
    checkOutput("t3_rdata_kept", bg_rdata, 8'hA5);

    // Request held for four bus cycles yields exactly four completions.
    clearCounts();
    bg_req = 1'b1; bg_we = 1'b0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 1; i <= 7; i++) begin
        ram_rdata = 8'($urandom);
        bg_addr   = 20'($urandom);
        applyStimulus(3'(i));
      end
    end
    bg_req = 1'b0;
    checkOutput("t4_done_pulses", obsDone, 4);

    // Bus write of 0x77 to 0x80001 with a pending background request.
    bg_we = 1'b0;
    applyStimulus(3'd1);
    applyStimulus(3'd2);
    clearCounts();
    bg_req = 1'b1; bus_sel = 1'b1; bus_we = 1'b1; bus_addr = 20'h80001; bus_wdata = 8'h77;
    for (int i = 3; i <= 7; i++) begin
      applyStimulus(3'(i));
      checkOutput("t5_no_gnt", bg_gnt, 1'b0);
    end
    checkOutput("t5_we_low", obsWeLow, 2);
    bus_sel = 1'b0; bus_we = 1'b0;
    applyStimulus(3'd1);
    checkOutput("t5_gnt_next_s1", bg_gnt, 1'b1);
    bg_req = 1'b0;
    for (int i = 2; i <= 7; i++) applyStimulus(3'(i));

    // Phase resync during a background write: abort, then retry at the next S=1.
    clearCounts();
    bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h44444; bg_wdata = 8'h99;
    applyStimulus(3'd1);
    applyStimulus(3'd2);
    applyStimulus(3'd1);
    checkOutput("t6_abort_idle_cs", ram_cs, 1'b0);
    for (int i = 2; i <= 7; i++) applyStimulus(3'(i));
    checkOutput("t6_abort_pulses", obsAbort, 1);
    checkOutput("t6_no_done", obsDone, 0);
    applyStimulus(3'd1);
    checkOutput("t6_retry_gnt", bg_gnt, 1'b1);
    bg_req = 1'b0;
    for (int i = 2; i <= 7; i++) applyStimulus(3'(i));

    // Asynchronous reset while the write strobe is active.
    clearCounts();
    bg_req = 1'b1; bg_we = 1'b1; bg_addr = 20'h0A0A0; bg_wdata = 8'h11;
    applyStimulus(3'd1);
    bg_req = 1'b0;
    applyStimulus(3'd2);
    #2 nRES = 1'b0;
    #1;
    modelReset();
    checkOutput("t7_gnt", bg_gnt, 1'b0);
    checkOutput("t7_cs", ram_cs, 1'b0);
    checkOutput("t7_we_n", ram_we_n, 1'b1);
    checkOutput("t7_oe", ram_oe, 1'b0);
    checkOutput("t7_addr", ram_addr, 20'h0);
    checkOutput("t7_rdata", bg_rdata, 8'h0);
    applyStimulus(3'd3);
    applyStimulus(3'd4);
    nRES = 1'b1;
    for (int i = 5; i <= 7; i++) applyStimulus(3'(i));
    checkOutput("t7_no_pulses", obsDone + obsAbort, 0);

    // Randomized traffic with occasional phase jumps and stray selects.
    sNow = 3'd7;
    busCyc = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(99) < 3) sNow = 3'($urandom_range(7));
      else sNow = (sNow == 3'd7 || sNow == 3'd0) ? 3'd1 : sNow + 3'd1;
      if (sNow == 3'd1) begin
        busCyc    = ($urandom_range(99) < 40);
        bus_we    = 1'($urandom);
        bus_addr  = 20'($urandom);
        bus_wdata = 8'($urandom);
      end
      bus_sel   = (sNow >= 3'd3) ? busCyc : ($urandom_range(99) < 5);
      bg_req    = ($urandom_range(99) < 70);
      bg_we     = 1'($urandom);
      bg_addr   = 20'($urandom);
      bg_wdata  = 8'($urandom);
      ram_rdata = 8'($urandom);
      applyStimulus(sNow);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
